// File: rtl/mem_tg_sched_pkg.sv
// Shared types and constants for the memory traffic-generator test scheduler.
package mem_tg_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_RUN  = 2'd1,
    SCHED_DONE = 2'd2
  } sched_state_e;

  // Bit positions inside a channel's packed result vector.
  localparam int RES_PASS = 0;
  localparam int RES_FAIL = 1;
  localparam int RES_TOUT = 2;
  localparam int RES_WDOG = 3;
  localparam int RES_W    = 4;

  localparam int HOLDOFF_DEF = 4;

endpackage

// File: rtl/mem_tg_sched_if.sv
// CSR-side command/status and per-channel TG signals of the test scheduler.
interface mem_tg_sched_if #(
  parameter int NUM_TG = 4,
  parameter int WDOG_W = 32
);
  logic              start;
  logic [NUM_TG-1:0] start_mask;
  logic              abort;
  logic [WDOG_W-1:0] wdog_limit;
  logic [NUM_TG-1:0] tg_pass;
  logic [NUM_TG-1:0] tg_fail;
  logic [NUM_TG-1:0] tg_timeout;
  logic [NUM_TG-1:0] tg_start;
  logic [NUM_TG-1:0] tg_active;
  logic              busy;
  logic              done;
  logic [NUM_TG-1:0] res_pass;
  logic [NUM_TG-1:0] res_fail;
  logic [NUM_TG-1:0] res_tout;
  logic [NUM_TG-1:0] res_wdog;

  modport master (
    output start, start_mask, abort, wdog_limit, tg_pass, tg_fail, tg_timeout,
    input  tg_start, tg_active, busy, done, res_pass, res_fail, res_tout, res_wdog
  );

  modport slave (
    input  start, start_mask, abort, wdog_limit, tg_pass, tg_fail, tg_timeout,
    output tg_start, tg_active, busy, done, res_pass, res_fail, res_tout, res_wdog
  );
endinterface

// File: rtl/mem_tg_sched_chan.sv
// One TG channel slot: holdoff, saturating watchdog, retire and sticky result decode.
module mem_tg_sched_chan
  import mem_tg_sched_pkg::*;
#(
  parameter int WDOG_W  = 32,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              launch,
  input  logic              kill,
  input  logic [WDOG_W-1:0] limit,
  input  logic              pass,
  input  logic              fail,
  input  logic              tout,
  output logic              active,
  output logic              retire,
  output logic [RES_W-1:0]  res
);
  localparam int HW = $clog2(HOLDOFF + 2);

  logic [HW-1:0]     hold_r;
  logic [WDOG_W-1:0] wcnt_r;
  logic              active_r;
  logic [RES_W-1:0]  res_r;
  logic              status_hit_s;
  logic              wdog_hit_s;
  logic [RES_W-1:0]  res_set_s;

  // Retire decision; status has priority over the watchdog in the same cycle.
  always_comb begin
    status_hit_s = active_r && (hold_r == '0) && (pass || fail || tout);
    wdog_hit_s   = active_r && (limit != '0) && (wcnt_r == limit);
    res_set_s    = '0;
    if (status_hit_s) begin
      res_set_s[RES_PASS] = pass & ~fail & ~tout;
      res_set_s[RES_FAIL] = fail;
      res_set_s[RES_TOUT] = tout;
    end else if (wdog_hit_s) begin
      res_set_s[RES_WDOG] = 1'b1;
    end else begin
      res_set_s = '0;
    end
  end

  // Channel activity, holdoff and watchdog counters, sticky results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
      hold_r   <= '0;
      wcnt_r   <= '0;
      res_r    <= '0;
    end else begin
      if (kill) begin
        active_r <= 1'b0;
        hold_r   <= '0;
        wcnt_r   <= '0;
      end else if (launch) begin
        active_r <= 1'b1;
        hold_r   <= HW'(HOLDOFF);
        wcnt_r   <= '0;
      end else if (active_r) begin
        active_r <= ~(status_hit_s | wdog_hit_s);
        if (hold_r != '0) hold_r <= hold_r - HW'(1);
        if (wcnt_r != '1) wcnt_r <= wcnt_r + WDOG_W'(1);
      end
      if (clr) res_r <= '0;
      else if (!kill) res_r <= res_r | res_set_s;
    end
  end

  assign active = active_r;
  assign retire = status_hit_s | wdog_hit_s;
  assign res    = res_r;
endmodule

// File: rtl/mem_tg_sched.sv
// Launches masked TG channels with bounded concurrency and gathers their results.
module mem_tg_sched
  import mem_tg_sched_pkg::*;
#(
  parameter int NUM_TG     = 4,
  parameter int MAX_ACTIVE = 2,
  parameter int WDOG_W     = 32,
  parameter int HOLDOFF    = HOLDOFF_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_tg_sched_if.slave bus
);
  localparam int CW = $clog2(NUM_TG + 1);
  localparam logic [1:0] ST_IDLE = SCHED_IDLE;
  localparam logic [1:0] ST_RUN  = SCHED_RUN;
  localparam logic [1:0] ST_DONE = SCHED_DONE;

  logic [1:0]        state_r, state_nx_s;
  logic [NUM_TG-1:0] pending_r, tg_start_r, src_s, launch_s, retire_s, active_s;
  logic [CW-1:0]     act_cnt_r, ret_cnt_s;
  logic [WDOG_W-1:0] limit_r;
  logic              busy_r, done_r, accept_s, kill_s;
  logic [RES_W-1:0]  res_a [NUM_TG];

  // Command decode, lowest-index dispatch, retire count and next state.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && bus.start;
    kill_s   = (state_r == ST_RUN) && bus.abort;
    src_s    = accept_s ? bus.start_mask : pending_r;
    if ((accept_s || ((state_r == ST_RUN) && !bus.abort)) && (act_cnt_r < CW'(MAX_ACTIVE))) begin
      launch_s = src_s & (~src_s + NUM_TG'(1));
    end else begin
      launch_s = '0;
    end
    ret_cnt_s = '0;
    for (int i = 0; i < NUM_TG; i++) ret_cnt_s = ret_cnt_s + CW'(retire_s[i]);
    case (state_r)
      ST_IDLE: state_nx_s = accept_s ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nx_s = ((pending_r == '0) && (act_cnt_r == '0)) ? ST_DONE : ST_RUN;
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM, pending vector, limit and active count; abort empties the run and
  // lets the empty-run check move to DONE on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pending_r  <= '0;
      tg_start_r <= '0;
      act_cnt_r  <= '0;
      limit_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      busy_r     <= (state_nx_s != ST_IDLE);
      done_r     <= (state_r == ST_RUN) && (state_nx_s == ST_DONE);
      tg_start_r <= launch_s;
      if (accept_s) begin
        pending_r <= bus.start_mask & ~launch_s;
        limit_r   <= bus.wdog_limit;
      end else if (kill_s) begin
        pending_r <= '0;
      end else begin
        pending_r <= pending_r & ~launch_s;
      end
      if (kill_s) act_cnt_r <= '0;
      else act_cnt_r <= act_cnt_r + CW'(|launch_s) - ret_cnt_s;
    end
  end

  for (genvar g = 0; g < NUM_TG; g++) begin : g_chan
    mem_tg_sched_chan #(.WDOG_W(WDOG_W), .HOLDOFF(HOLDOFF)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept_s),
      .launch (launch_s[g]),
      .kill   (kill_s),
      .limit  (limit_r),
      .pass   (bus.tg_pass[g]),
      .fail   (bus.tg_fail[g]),
      .tout   (bus.tg_timeout[g]),
      .active (active_s[g]),
      .retire (retire_s[g]),
      .res    (res_a[g])
    );
  end

  // Unpack per-channel result vectors onto the status buses.
  always_comb begin
    bus.res_pass = '0;
    bus.res_fail = '0;
    bus.res_tout = '0;
    bus.res_wdog = '0;
    for (int i = 0; i < NUM_TG; i++) begin
      bus.res_pass[i] = res_a[i][RES_PASS];
      bus.res_fail[i] = res_a[i][RES_FAIL];
      bus.res_tout[i] = res_a[i][RES_TOUT];
      bus.res_wdog[i] = res_a[i][RES_WDOG];
    end
  end

  assign bus.tg_start  = tg_start_r;
  assign bus.tg_active = active_s;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule
